// File: rtl/cache_bus_mem_responder_pkg.sv
// Shared cache-bus types for the LSU/cache initiators and the memory-side responder.
// Initiators port-type their response input as cache_bus_resp_t.
package cache_bus_mem_responder_pkg;

    localparam logic [1:0] MEM_TYPE_BYTE = 2'd0;
    localparam logic [1:0] MEM_TYPE_HALF = 2'd1;
    localparam logic [1:0] MEM_TYPE_WORD = 2'd2;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic        burst;
        logic        cached;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  data_strobe;
        logic        data_ok;
        logic        data_last;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] r_data;
    } cache_bus_resp_t;

    // Expands a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strobe_mask(input logic [3:0] strobe);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/cache_bus_mem_responder_sp_ram_bytewen.sv
// Single-port word array with asynchronous read and per-byte write enable.
// Contents are deliberately not reset.
module sp_ram_bytewen
    import cache_bus_mem_responder_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] mask;

    assign mask  = strobe_mask(be);
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
        end
    end

endmodule

// File: rtl/cache_bus_mem_responder.sv
// Memory-side cache-bus responder: one request at a time, fixed access latency,
// single or wrapping (critical-word-first) burst reads and byte-strobed writes.
module cache_bus_mem_responder
    import cache_bus_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int BURST_LEN = 4,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  cache_bus_req_t  bus_req_i,
    output cache_bus_resp_t bus_resp_o,
    output logic [2:0]      dbg_state,
    output logic            dbg_cached
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int OFF_W = $clog2(BURST_LEN);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_DATA = 3'b100
    } state_t;

    state_t             state, state_nxt;
    logic               run_q;
    logic               write_q, burst_q, cached_q;
    logic [IDX_W-1:0]   start_idx;
    logic [OFF_W-1:0]   beat_cnt;
    logic [LAT_W-1:0]   lat_cnt;

    logic               accept, last_beat, beat_done, xfer_end, ram_we;
    logic [OFF_W-1:0]   off_sum;
    logic [IDX_W-1:0]   beat_addr;
    logic [31:0]        ram_rdata;
    logic               unused_req_bits;

    assign unused_req_bits = ^{bus_req_i.addr[31:IDX_W+2], bus_req_i.addr[1:0]};

    // run_q keeps ready low during reset and for no longer than the first edge after it.
    assign accept    = (state == ST_IDLE) && run_q && bus_req_i.valid;
    assign last_beat = burst_q ? (beat_cnt == OFF_W'(BURST_LEN - 1)) : 1'b1;
    assign beat_done = (state == ST_DATA) && bus_req_i.data_ok;
    assign xfer_end  = beat_done && (last_beat || (write_q && bus_req_i.data_last));
    assign ram_we    = beat_done && write_q;

    // Wrap inside the aligned line; singles always have beat_cnt == 0.
    assign off_sum   = start_idx[OFF_W-1:0] + beat_cnt;
    assign beat_addr = burst_q ? {start_idx[IDX_W-1:OFF_W], off_sum} : start_idx;

    sp_ram_bytewen #(
        .DEPTH (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (bus_req_i.data_strobe),
        .addr  (beat_addr),
        .wdata (bus_req_i.w_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (LATENCY > 1) ? ST_WAIT : ST_DATA;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_W'(1)) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            write_q   <= 1'b0;
            burst_q   <= 1'b0;
            cached_q  <= 1'b0;
            start_idx <= '0;
            beat_cnt  <= '0;
            lat_cnt   <= '0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                write_q   <= bus_req_i.write;
                burst_q   <= bus_req_i.burst;
                cached_q  <= bus_req_i.cached;
                start_idx <= bus_req_i.addr[IDX_W+1:2];
                beat_cnt  <= '0;
                lat_cnt   <= LAT_W'(LATENCY - 1);
            end
            if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (beat_done) begin
                beat_cnt <= beat_cnt + OFF_W'(1);
            end
        end
    end

    always_comb begin
        bus_resp_o.ready     = (state == ST_IDLE) && run_q;
        bus_resp_o.data_ok   = (state == ST_DATA);
        bus_resp_o.data_last = (state == ST_DATA) && !write_q && last_beat;
        bus_resp_o.r_data    = (state == ST_DATA) ? ram_rdata : 32'h0;
    end

    assign dbg_state  = state;
    assign dbg_cached = cached_q;

endmodule
